alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised multi-cycle ALU for the RV64 core; generalises the combinational add/sub unit.
//  Single-cycle logic/shift/compare ops, iterative shift-add multiply, optional iterative divide.
//  Start/valid handshake so the execute stage can stall on long ops; sits between ID/EX regs and EX/MEM.
// PARAMETERS
//  WORDSIZE  64  operand/result width (>=8, power of 2); SHW=$clog2(WORDSIZE) derived, not overridable
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous reset, active low
//  start        in   1         launch op; accepted only when ready=1
//  operation    in   4         opcode, sampled with start
//  input_a      in   WORDSIZE  operand A, sampled with start
//  input_b      in   WORDSIZE  operand B, sampled with start
//  ready        out  1         idle, can accept start
//  valid        out  1         one-cycle pulse: result/flags valid
//  result       out  WORDSIZE  result, held until next accepted start
//  overflow     out  1         overflow flag, held with result
//  div_by_zero  out  1         divisor was 0 (tied 0 without ALU_DIV_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, ready=1, valid=0, result=0, overflow=0, div_by_zero=0.
//  - Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra,
//    1000 slt (signed, result 0/1), 1001 sltu, 1010 mul (low W bits, unsigned), 1100 divu, 1101 remu.
//  - Undefined opcodes (and 1100/1101 without macro): result=0, overflow=0, single-cycle latency.
//  - Shifts use input_b[SHW-1:0] only; upper bits of B ignored.
//  - overflow: add/sub = signed two's-complement overflow; mul = high W bits of full product nonzero;
//    all other ops 0.
//  - FSM: IDLE -> (start) -> SINGLE or ITER; SINGLE -> DONE; ITER -> DONE after WORDSIZE steps;
//    DONE -> IDLE. valid=1 only in DONE cycle; ready=1 only in IDLE (ready=0 in DONE).
//  - Latency (start edge to valid high): single-cycle ops 2 cycles; mul/divu/remu WORDSIZE+2.
//  - Mul: 2W-bit accumulator, one multiplier bit per cycle, LSB first.
//  - Back-to-back: next start accepted in IDLE cycle following DONE; start while ready=0 is ignored
//    (no queueing, no error).
//  - Operands/opcode latched at accept; input changes during ITER have no effect.
//  - Reset asserted mid-ITER aborts op: no valid pulse, outputs return to reset values.
//  - result/overflow/div_by_zero update only in DONE cycle; stable otherwise.
// CONFIGURATION
//  - ALU_DIV_EN defined: restoring unsigned divider, 1 quotient bit/cycle, WORDSIZE steps.
//    divu -> quotient, remu -> remainder. B=0: quotient all ones, remainder=A, div_by_zero=1,
//    full latency kept. div_by_zero cleared on next op completion.
//  - ALU_DIV_EN undefined: no divider logic; 1100/1101 behave as undefined; div_by_zero=0.
// TESTING (WORDSIZE=64)
//  - Reset mid-mul: start mul, rst_n=0 at cycle 10 -> ready=1, valid=0, result=0; no later valid.
//  - add 0x7FFF_FFFF_FFFF_FFFF+1 -> valid 2 cycles after start, result 0x8000_0000_0000_0000, overflow=1;
//    sub 5-7 -> 0xFFFF_FFFF_FFFF_FFFE, overflow=0.
//  - sra 0x8000_0000_0000_0000 by B=0x41 -> shamt 1, result 0xC000_0000_0000_0000;
//    slt(-1,1)=1, sltu(-1,1)=0.
//  - mul 0x1_0000_0000 * 0x1_0000_0000 -> result 0, overflow=1, valid exactly 66 cycles after start;
//    start pulses during busy ignored; mul 12*13 -> 156, overflow=0.
//  - ALU_DIV_EN: divu 100/7 -> 14, remu -> 2; divu 5/0 -> 0xFFFF_FFFF_FFFF_FFFF, div_by_zero=1;
//    without macro opcode 1100 -> result 0 after 2 cycles.
//  - Back-to-back: add then and issued on first ready cycles -> two valid pulses 3 cycles apart,
//    correct results.

Source files
------------

// File: rtl/alu_multicycle.sv
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Multi-cycle ALU with single-cycle logic/shift/compare ops,
//            iterative shift-add multiply and, when ALU_DIV_EN is defined,
//            an iterative restoring unsigned divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multicycle #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          operation,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  output logic                ready,
  output logic                valid,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow,
  output logic                div_by_zero
);

  localparam int SHW = $clog2(WORDSIZE);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDSIZE);

  localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010,
                         OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_SLL  = 4'b0101,
                         OP_SRL  = 4'b0110, OP_SRA  = 4'b0111, OP_SLT  = 4'b1000,
                         OP_SLTU = 4'b1001, OP_MUL  = 4'b1010;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100, OP_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SINGLE = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;

  state_t                state, next_state;
  logic [3:0]            op_r;
  logic [WORDSIZE-1:0]   op_a, op_b;
  logic [2*WORDSIZE-1:0] acc, acc_step, acc_init;
  logic [CW-1:0]         count;
  logic                  launch_iter;
  logic [WORDSIZE-1:0]   single_res, iter_res;
  logic                  single_ovf, iter_ovf;
  logic [WORDSIZE-1:0]   sum, diff;
  logic [SHW-1:0]        shamt;
  logic [WORDSIZE:0]     mul_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = launch_iter ? ITER : SINGLE;
      end
      SINGLE: next_state = DONE;
      ITER:   if (count == LAST) next_state = DONE;
      DONE: begin
        valid      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sum        = op_a + op_b;
    diff       = op_a - op_b;
    shamt      = op_b[SHW-1:0];
    single_res = '0;
    single_ovf = 1'b0;
    case (op_r)
      OP_ADD: begin
        single_res = sum;
        single_ovf = (op_a[WORDSIZE-1] == op_b[WORDSIZE-1]) && (sum[WORDSIZE-1] != op_a[WORDSIZE-1]);
      end
      OP_SUB: begin
        single_res = diff;
        single_ovf = (op_a[WORDSIZE-1] != op_b[WORDSIZE-1]) && (diff[WORDSIZE-1] != op_a[WORDSIZE-1]);
      end
      OP_AND:  single_res = op_a & op_b;
      OP_OR:   single_res = op_a | op_b;
      OP_XOR:  single_res = op_a ^ op_b;
      OP_SLL:  single_res = op_a << shamt;
      OP_SRL:  single_res = op_a >> shamt;
      OP_SRA:  single_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  single_res = {{(WORDSIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: single_res = {{(WORDSIZE-1){1'b0}}, op_a < op_b};
      default: ;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  assign mul_add = {1'b0, acc[2*WORDSIZE-1:WORDSIZE]} + {1'b0, op_a};

`ifdef ALU_DIV_EN
  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  logic [WORDSIZE:0] div_shift, div_trial;
  logic              dbz_r;

  assign div_shift = acc[2*WORDSIZE-1:WORDSIZE-1];
  assign div_trial = div_shift - {1'b0, op_b};

  always_comb begin
    launch_iter = (operation == OP_MUL) || (operation == OP_DIVU) || (operation == OP_REMU);
    acc_init    = (operation == OP_MUL) ? {{WORDSIZE{1'b0}}, input_b} : {{WORDSIZE{1'b0}}, input_a};
    iter_ovf    = 1'b0;
    if (op_r == OP_MUL) begin
      acc_step = acc[0] ? {mul_add, acc[WORDSIZE-1:1]} : {1'b0, acc[2*WORDSIZE-1:1]};
      iter_res = acc[WORDSIZE-1:0];
      iter_ovf = |acc[2*WORDSIZE-1:WORDSIZE];
    end else begin
      acc_step = div_trial[WORDSIZE] ? {div_shift[WORDSIZE-1:0], acc[WORDSIZE-2:0], 1'b0}
                                     : {div_trial[WORDSIZE-1:0], acc[WORDSIZE-2:0], 1'b1};
      iter_res = (op_r == OP_REMU) ? acc[2*WORDSIZE-1:WORDSIZE] : acc[WORDSIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbz_r <= 1'b0;
    else if (next_state == DONE)
      dbz_r <= (state == ITER) && (op_r != OP_MUL) && (op_b == '0);
  end

  assign div_by_zero = dbz_r;
`else
  always_comb begin
    launch_iter = (operation == OP_MUL);
    acc_init    = {{WORDSIZE{1'b0}}, input_b};
    acc_step    = acc[0] ? {mul_add, acc[WORDSIZE-1:1]} : {1'b0, acc[2*WORDSIZE-1:1]};
    iter_res    = acc[WORDSIZE-1:0];
    iter_ovf    = |acc[2*WORDSIZE-1:WORDSIZE];
  end

  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      count    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_r  <= operation;
        op_a  <= input_a;
        op_b  <= input_b;
        acc   <= acc_init;
        count <= '0;
      end else if (state == ITER && count != LAST) begin
        acc   <= acc_step;
        count <= count + CW'(1);
      end
      if (next_state == DONE) begin
        result   <= (state == ITER) ? iter_res : single_res;
        overflow <= (state == ITER) ? iter_ovf : single_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Directed vector table plus multi-cycle corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multicycle;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   operation;
  logic [W-1:0] input_a, input_b;
  logic         ready, valid, overflow, div_by_zero;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_multicycle #(.WORDSIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .input_a(input_a), .input_b(input_b), .ready(ready), .valid(valid),
    .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic o, output logic d, output int lat);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1; operation = op; input_a = a; input_b = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (!valid && lat < 300);
    r = result; o = overflow; d = div_by_zero;
  endtask

  initial begin
    logic [W-1:0] r, prev;
    logic         o, d;
    int           lat, t1, t2, nvalid;

    rst_n = 1'b0; start = 1'b0; operation = '0; input_a = '0; input_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", W'(ready), W'(1));
    chk("reset_valid", W'(valid), W'(0));
    chk("reset_result", result, '0);
    chk("reset_ovf", W'(overflow), W'(0));
    chk("reset_dbz", W'(div_by_zero), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0001, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0010, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h000F_000F_000F_000F, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0011, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0FFF_0FFF_0FFF_0FFF, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0100, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0101, 64'h1, 64'h43, 64'h8, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0110, 64'h8000_0000_0000_0000, 64'h4, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0111, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b1010, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 1'b1, 1'b0, 66});
    vecs.push_back('{4'b1010, 64'd12, 64'd13, 64'd156, 1'b0, 1'b0, 66});
    vecs.push_back('{4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 66});
    vecs.push_back('{4'b1011, 64'd9, 64'd9, 64'h0, 1'b0, 1'b0, 2});
`ifdef ALU_DIV_EN
    vecs.push_back('{4'b1100, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 66});
    vecs.push_back('{4'b1101, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 66});
    vecs.push_back('{4'b1100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 66});
    vecs.push_back('{4'b1101, 64'd5, 64'd0, 64'd5, 1'b0, 1'b1, 66});
`else
    vecs.push_back('{4'b1100, 64'd100, 64'd7, 64'h0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b1101, 64'd100, 64'd7, 64'h0, 1'b0, 1'b0, 2});
`endif
    vecs.push_back('{4'b0000, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 2});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, o, d, lat);
      chk($sformatf("vec%0d_res", i), r, vecs[i].res);
      chk($sformatf("vec%0d_ovf", i), W'(o), W'(vecs[i].ovf));
      chk($sformatf("vec%0d_dbz", i), W'(d), W'(vecs[i].dbz));
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(vecs[i].lat));
    end

    // Busy mul with stray start pulses: result held, start ignored.
    @(negedge clk);
    prev = result;
    start = 1'b1; operation = 4'b1010; input_a = 64'h1_0000_0000; input_b = 64'h1_0000_0000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == 3) || (lat == 4) || (lat == 20);
      operation = 4'b0000; input_a = 64'd1; input_b = 64'd1;
      if (lat == 30) begin
        chk("busy_ready", W'(ready), W'(0));
        chk("busy_result_held", result, prev);
      end
    end while (!valid && lat < 300);
    chk("busy_mul_lat", W'(lat), W'(66));
    chk("busy_mul_res", result, 64'h0);
    chk("busy_mul_ovf", W'(overflow), W'(1));
    @(negedge clk);
    chk("busy_after_ready", W'(ready), W'(1));
    chk("busy_after_valid", W'(valid), W'(0));

    // Back-to-back on first ready cycles.
    run_op(4'b0000, 64'd40, 64'd2, r, o, d, lat);
    t1 = cyc;
    chk("b2b_add_res", r, 64'd42);
    run_op(4'b0010, 64'hF0, 64'h3C, r, o, d, lat);
    t2 = cyc;
    chk("b2b_and_res", r, 64'h30);
    chk("b2b_gap", W'(t2 - t1), W'(3));

    // Reset mid-mul aborts with no later valid.
    @(negedge clk);
    start = 1'b1; operation = 4'b1010; input_a = 64'd3; input_b = 64'd5;
    lat = 0;
    nvalid = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (valid) nvalid++;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", W'(ready), W'(1));
    chk("rst_mid_valid", W'(valid), W'(0));
    chk("rst_mid_result", result, '0);
    chk("rst_mid_ovf", W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("rst_mid_no_valid", W'(nvalid), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
